pipeline_ctrl: RTL

- Hazard and sequencing controller for the five-stage fetch/decode/exec/memacc/writeback pipeline.
- Generates stall, flush and forwarding-select controls from per-stage register addresses and the exec-stage redirect.
- Tracks per-stage valid bits and sequences boot, run, drain-to-halt and halted.
- Keeps cycle, stall and flush performance counters.

---
 rtl/pipeline_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard/sequencing controller: stall, flush and forwarding selects, boot/run/drain/halt FSM, perf counters.
// Controls are combinational from stage addresses; state, valid bits and counters update on the rising edge; no backpressure of its own.
module pipeline_ctrl #(
  parameter int BOOT_CYCLES  = 2,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_halt_req,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_rd_we,
  input  logic [1:0]       ex_res_src,
  input  logic             ex_pc_src,
  input  logic [4:0]       mem_rd,
  input  logic             mem_rd_we,
  input  logic [4:0]       wb_rd,
  input  logic             wb_rd_we,
  output logic             stall_fetch,
  output logic             stall_decode,
  output logic             flush_decode,
  output logic             flush_exec,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_DRAIN, S_HALTED} state_e;

  localparam int SEQ_MAX = (BOOT_CYCLES > DRAIN_CYCLES) ? BOOT_CYCLES : DRAIN_CYCLES;
  localparam int SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;

  state_e           state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             v_d_q, v_e_q, v_m_q, v_w_q;
  logic [CNT_W-1:0] cycle_q, stall_q, flush_q;
  logic             lu;

  // x0 is hardwired zero, so it never produces a dependency
  always_comb begin
    fwd_a = 2'b00;
    if (ex_rs1 != 5'd0 && v_m_q && mem_rd_we && mem_rd == ex_rs1)      fwd_a = 2'b10;
    else if (ex_rs1 != 5'd0 && v_w_q && wb_rd_we && wb_rd == ex_rs1)   fwd_a = 2'b01;
    fwd_b = 2'b00;
    if (ex_rs2 != 5'd0 && v_m_q && mem_rd_we && mem_rd == ex_rs2)      fwd_b = 2'b10;
    else if (ex_rs2 != 5'd0 && v_w_q && wb_rd_we && wb_rd == ex_rs2)   fwd_b = 2'b01;
  end

  assign lu = v_e_q & v_d_q & ex_rd_we & (ex_res_src == 2'b01) & (ex_rd != 5'd0) &
              ((ex_rd == dec_rs1) | (ex_rd == dec_rs2));

  always_comb begin
    state_d      = state_q;
    seq_d        = seq_q;
    stall_fetch  = 1'b1;
    stall_decode = 1'b1;
    flush_decode = 1'b1;
    flush_exec   = 1'b1;
    halted       = 1'b0;
    case (state_q)
      S_BOOT: begin
        if (seq_q == SEQ_W'(BOOT_CYCLES - 1)) begin
          state_d = S_RUN;
          seq_d   = '0;
        end else begin
          seq_d = seq_q + SEQ_W'(1);
        end
      end
      S_RUN: begin
        // a redirect makes the decode slot wrong-path, so it overrides the load-use stall
        stall_fetch  = lu & ~ex_pc_src;
        stall_decode = lu & ~ex_pc_src;
        flush_exec   = lu | ex_pc_src;
        flush_decode = ex_pc_src;
        if (v_d_q && dec_halt_req && !ex_pc_src && !lu) begin
          state_d = S_DRAIN;
          seq_d   = '0;
        end
      end
      S_DRAIN: begin
        flush_decode = 1'b0;
        if (seq_q == SEQ_W'(DRAIN_CYCLES - 1)) begin
          state_d = S_HALTED;
          seq_d   = '0;
        end else begin
          seq_d = seq_q + SEQ_W'(1);
        end
      end
      S_HALTED: halted = 1'b1;
      default:  state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      seq_q   <= '0;
      v_d_q   <= 1'b0;
      v_e_q   <= 1'b0;
      v_m_q   <= 1'b0;
      v_w_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      v_w_q   <= v_m_q;
      v_m_q   <= v_e_q;
      v_e_q   <= v_d_q & ~stall_decode & ~flush_exec;
      if (!stall_decode) v_d_q <= ~flush_decode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else if (state_q != S_HALTED) begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (state_q == S_RUN && stall_decode) stall_q <= stall_q + CNT_W'(1);
      if (state_q == S_RUN && ex_pc_src)    flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cycle_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule
